// File: rtl/pb_loader_pkg.sv
// Shared constants and helpers for the KCPSM3 program loader.
// Frame: START, CNT_HI, CNT_LO, N x (B0,B1,B2), CHK.
package pb_loader_pkg;

   localparam int RAM_AW    = 10;
   localparam int RAM_DW    = 18;
   localparam int MAX_WORDS = 1 << RAM_AW;

   localparam logic [7:0] START_BYTE_DEF     = 8'hA5;
   localparam logic [7:0] ACK_BYTE_DEF       = 8'h06;
   localparam logic [7:0] NAK_BYTE_DEF       = 8'h15;
   localparam int         TIMEOUT_CYCLES_DEF = 1000000;

   typedef logic [3:0] state_t;

   localparam state_t ST_IDLE   = 4'd0;
   localparam state_t ST_CNT_HI = 4'd1;
   localparam state_t ST_CNT_LO = 4'd2;
   localparam state_t ST_B0     = 4'd3;
   localparam state_t ST_B1     = 4'd4;
   localparam state_t ST_B2     = 4'd5;
   localparam state_t ST_WR     = 4'd6;
   localparam state_t ST_CHK    = 4'd7;
   localparam state_t ST_RESP   = 4'd8;

   // Only B0[1:0] carries data; it lands in the parity bits of the word.
   function automatic logic [RAM_DW-1:0] pack_word(input logic [7:0] b0,
                                                   input logic [7:0] b1,
                                                   input logic [7:0] b2);
      return {b0[1:0], b1, b2};
   endfunction

endpackage

// File: rtl/pb_loader_timeout.sv
// Inter-byte silence detector: a down-counter that restarts on clear and
// flags expiry on the cycle that completes TIMEOUT_CYCLES-1 silent cycles.
module pb_loader_timeout
   import pb_loader_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic en,
   output logic expired
);

   localparam int W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   // Reload to T-2 so that expiry coincides with the (T-1)th silent cycle.
   localparam logic [W-1:0] RELOAD = W'(TIMEOUT_CYCLES - 2);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= RELOAD;
      end else if (en && (cnt != '0)) begin
         cnt <= cnt - W'(1);
      end
   end

   assign expired = en && (cnt == '0);

endmodule

// File: rtl/pb_prog_loader.sv
// Byte-stream program loader: writes framed 18-bit words into the program
// RAM write port, holds the processor in reset, and answers ACK or NAK.
module pb_prog_loader
   import pb_loader_pkg::*;
#(
   parameter logic [7:0] START_BYTE     = START_BYTE_DEF,
   parameter int         TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
   parameter logic [7:0] ACK_BYTE       = ACK_BYTE_DEF,
   parameter logic [7:0] NAK_BYTE       = NAK_BYTE_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [15:0]       ram_di,
   output logic [1:0]        ram_dip,
   output logic              ram_en,
   output logic              ram_we,
   output logic              proc_reset,
   output logic              busy
);

   state_t      state;
   logic [7:0]  cnt_hi;
   logic [7:0]  chk;
   logic [10:0] n_words;
   logic [10:0] word_cnt;
   logic [1:0]  w_hi;
   logic [7:0]  w_mid;
   logic        resp_ack;

   logic        in_frame;
   logic        to_expired;
   logic [7:0]  chk_next;
   logic [15:0] n_full;
   logic [10:0] word_cnt_inc;

   assign in_frame     = (state != ST_IDLE) && (state != ST_RESP);
   assign chk_next     = chk ^ rx_data;
   assign n_full       = {cnt_hi, rx_data};
   assign word_cnt_inc = word_cnt + 11'd1;
   assign busy         = (state != ST_IDLE);
   assign ram_en       = ram_we;

   pb_loader_timeout #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk    (clk),
      .reset  (reset),
      .clear  (rx_valid || !in_frame),
      .en     (in_frame && !rx_valid),
      .expired(to_expired)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         tx_data    <= '0;
         tx_valid   <= 1'b0;
         ram_we     <= 1'b0;
         ram_addr   <= '0;
         ram_di     <= '0;
         ram_dip    <= '0;
         proc_reset <= 1'b0;
         chk        <= '0;
         cnt_hi     <= '0;
         n_words    <= '0;
         word_cnt   <= '0;
         w_hi       <= '0;
         w_mid      <= '0;
         resp_ack   <= 1'b0;
      end else begin
         ram_we <= 1'b0;
         // Expiry only asserts in-frame without rx_valid, so it preempts all.
         if (to_expired) begin
            tx_data  <= NAK_BYTE;
            resp_ack <= 1'b0;
            tx_valid <= 1'b1;
            state    <= ST_RESP;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (rx_valid && (rx_data == START_BYTE)) begin
                     proc_reset <= 1'b1;
                     chk        <= '0;
                     word_cnt   <= '0;
                     ram_addr   <= '0;
                     state      <= ST_CNT_HI;
                  end
               end
               ST_CNT_HI: begin
                  if (rx_valid) begin
                     cnt_hi <= rx_data;
                     chk    <= chk_next;
                     state  <= ST_CNT_LO;
                  end
               end
               ST_CNT_LO: begin
                  if (rx_valid) begin
                     chk     <= chk_next;
                     n_words <= n_full[10:0];
                     if (n_full > 16'(MAX_WORDS)) begin
                        tx_data  <= NAK_BYTE;
                        resp_ack <= 1'b0;
                        tx_valid <= 1'b1;
                        state    <= ST_RESP;
                     end else if (n_full == 16'd0) begin
                        state <= ST_CHK;
                     end else begin
                        state <= ST_B0;
                     end
                  end
               end
               ST_B0: begin
                  if (rx_valid) begin
                     w_hi  <= rx_data[1:0];
                     chk   <= chk_next;
                     state <= ST_B1;
                  end
               end
               ST_B1: begin
                  if (rx_valid) begin
                     w_mid <= rx_data;
                     chk   <= chk_next;
                     state <= ST_B2;
                  end
               end
               ST_B2: begin
                  if (rx_valid) begin
                     chk               <= chk_next;
                     {ram_dip, ram_di} <= pack_word({6'd0, w_hi}, w_mid, rx_data);
                     ram_we            <= 1'b1;
                     state             <= ST_WR;
                  end
               end
               ST_WR: begin
                  word_cnt <= word_cnt_inc;
                  if (word_cnt_inc == n_words) begin
                     // Last word: address stays put, so 1023 never wraps to 0.
                     if (rx_valid) begin
                        tx_data  <= (rx_data == chk) ? ACK_BYTE : NAK_BYTE;
                        resp_ack <= (rx_data == chk);
                        tx_valid <= 1'b1;
                        state    <= ST_RESP;
                     end else begin
                        state <= ST_CHK;
                     end
                  end else begin
                     ram_addr <= ram_addr + 10'd1;
                     if (rx_valid) begin
                        w_hi  <= rx_data[1:0];
                        chk   <= chk_next;
                        state <= ST_B1;
                     end else begin
                        state <= ST_B0;
                     end
                  end
               end
               ST_CHK: begin
                  if (rx_valid) begin
                     tx_data  <= (rx_data == chk) ? ACK_BYTE : NAK_BYTE;
                     resp_ack <= (rx_data == chk);
                     tx_valid <= 1'b1;
                     state    <= ST_RESP;
                  end
               end
               ST_RESP: begin
                  if (tx_ready) begin
                     tx_valid <= 1'b0;
                     state    <= ST_IDLE;
                     if (resp_ack) begin
                        proc_reset <= 1'b0;
                     end
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pb_prog_loader.sv
// Directed bench for pb_prog_loader: framed loads, checksum and size errors,
// timeout abort, response back-pressure and mid-frame reset.
module tb_pb_prog_loader;
   import pb_loader_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [9:0]  ram_addr;
   logic [15:0] ram_di;
   logic [1:0]  ram_dip;
   logic        ram_en;
   logic        ram_we;
   logic        proc_reset;
   logic        busy;

   int checks = 0;
   int errors = 0;
   int wr_count = 0;
   logic [27:0] exp_q[$];

   pb_prog_loader #(.TIMEOUT_CYCLES(50)) dut (
      .clk       (clk),
      .reset     (reset),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .ram_addr  (ram_addr),
      .ram_di    (ram_di),
      .ram_dip   (ram_dip),
      .ram_en    (ram_en),
      .ram_we    (ram_we),
      .proc_reset(proc_reset),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1, "watchdog expired");
   end

   // Write scoreboard: every observed write pulse must match the queue head.
   always @(negedge clk) begin
      logic [27:0] exp;
      if (ram_we === 1'b1 || ram_en === 1'b1) begin
         checks++;
         if (ram_en !== ram_we) begin
            errors++;
            $display("FAIL ram_en_eq_we: ram_en %b ram_we %b, required equal", ram_en, ram_we);
         end
      end
      if (ram_we === 1'b1) begin
         wr_count++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: addr %h dip %h di %h, required no write", ram_addr, ram_dip, ram_di);
         end else begin
            exp = exp_q.pop_front();
            if ({ram_addr, ram_dip, ram_di} !== exp) begin
               errors++;
               $display("FAIL write_data: got addr %h dip %h di %h, required addr %h dip %h di %h",
                        ram_addr, ram_dip, ram_di, exp[27:18], exp[17:16], exp[15:0]);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic send(input logic [7:0] b);
      send_byte(b);
      tick();
   endtask

   task automatic handshake();
      tx_ready = 1'b1;
      tick();
      tx_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      rx_valid = 1'b0;
      rx_data = 8'h00;
      tx_ready = 1'b0;
      repeat (3) tick();
      reset = 1'b0;
      checks++;
      if ({tx_valid, tx_data, ram_we, ram_en, ram_addr, ram_di, ram_dip, proc_reset, busy} !== 39'd0) begin
         errors++;
         $display("FAIL reset_outputs: tx_valid %b tx_data %h we %b en %b addr %h di %h dip %h proc_reset %b busy %b, required all 0",
                  tx_valid, tx_data, ram_we, ram_en, ram_addr, ram_di, ram_dip, proc_reset, busy);
      end
      send(8'h11);
      send(8'h06);
      checks++;
      if (busy !== 1'b0 || proc_reset !== 1'b0) begin
         errors++;
         $display("FAIL idle_ignore: busy %b proc_reset %b, required 0 0", busy, proc_reset);
      end
   endtask

   task automatic test_two_word(input logic [7:0] chk_byte, input logic [7:0] resp,
                                input logic proc_after, input bit stall);
      exp_q.push_back({10'd0, 2'd2, 16'hA5C3});
      exp_q.push_back({10'd1, 2'd0, 16'h0001});
      send(8'hA5);
      checks++;
      if (busy !== 1'b1 || proc_reset !== 1'b1) begin
         errors++;
         $display("FAIL start_accept: busy %b proc_reset %b, required 1 1", busy, proc_reset);
      end
      send(8'h00); send(8'h02); send(8'h02); send(8'hA5);
      send_byte(8'hC3);
      checks++;
      if (ram_we !== 1'b1 || ram_addr !== 10'd0) begin
         errors++;
         $display("FAIL write0_latency: ram_we %b addr %h, required 1 000", ram_we, ram_addr);
      end
      tick();
      send(8'h00); send(8'h00);
      send_byte(8'h01);
      checks++;
      if (ram_we !== 1'b1 || ram_addr !== 10'd1) begin
         errors++;
         $display("FAIL write1_latency: ram_we %b addr %h, required 1 001", ram_we, ram_addr);
      end
      tick();
      send_byte(chk_byte);
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== resp || proc_reset !== 1'b1) begin
         errors++;
         $display("FAIL resp_latency: tx_valid %b tx_data %h proc_reset %b, required 1 %h 1",
                  tx_valid, tx_data, proc_reset, resp);
      end
      if (stall) begin
         for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== resp) begin
               errors++;
               $display("FAIL resp_stall: cycle %0d tx_valid %b tx_data %h, required 1 %h", i, tx_valid, tx_data, resp);
            end
         end
      end
      handshake();
      checks++;
      if (tx_valid !== 1'b0 || busy !== 1'b0 || proc_reset !== proc_after) begin
         errors++;
         $display("FAIL resp_done: tx_valid %b busy %b proc_reset %b, required 0 0 %b",
                  tx_valid, busy, proc_reset, proc_after);
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL writes_seen: %0d pending, required 0", exp_q.size());
      end
   endtask

   task automatic test_oversize();
      int wr_before;
      wr_before = wr_count;
      send(8'hA5);
      send(8'h04);
      send_byte(8'h01);
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== 8'h15) begin
         errors++;
         $display("FAIL oversize_nak: tx_valid %b tx_data %h, required 1 15", tx_valid, tx_data);
      end
      tick();
      send(8'h00); send(8'h11); send(8'hA5); send(8'h22);
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== 8'h15 || busy !== 1'b1) begin
         errors++;
         $display("FAIL oversize_ignore: tx_valid %b tx_data %h busy %b, required 1 15 1", tx_valid, tx_data, busy);
      end
      handshake();
      checks++;
      if (busy !== 1'b0 || proc_reset !== 1'b1 || wr_count != wr_before) begin
         errors++;
         $display("FAIL oversize_done: busy %b proc_reset %b writes %0d, required 0 1 0",
                  busy, proc_reset, wr_count - wr_before);
      end
   endtask

   task automatic test_full_frame();
      logic [7:0] chk;
      logic [7:0] b0, b1, b2;
      logic [9:0] iv;
      int wr_before;
      wr_before = wr_count;
      chk = 8'h04;
      send(8'hA5); send(8'h04); send(8'h00);
      for (int i = 0; i < 1024; i++) begin
         iv = 10'(i);
         b0 = 8'hA8 | {6'd0, iv[9:8]};
         b1 = iv[7:0];
         b2 = ~iv[7:0];
         chk = chk ^ b0 ^ b1 ^ b2;
         exp_q.push_back({iv, iv[9:8], b1, b2});
         send(b0); send(b1); send(b2);
      end
      checks++;
      if (ram_addr !== 10'd1023 || wr_count - wr_before != 1024) begin
         errors++;
         $display("FAIL full_frame_writes: addr %h writes %0d, required 3ff 1024", ram_addr, wr_count - wr_before);
      end
      send_byte(chk);
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== 8'h06) begin
         errors++;
         $display("FAIL full_frame_ack: tx_valid %b tx_data %h, required 1 06", tx_valid, tx_data);
      end
      handshake();
      checks++;
      if (proc_reset !== 1'b0 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL full_frame_done: proc_reset %b pending %0d, required 0 0", proc_reset, exp_q.size());
      end
   endtask

   task automatic test_timeout();
      int wr_before;
      wr_before = wr_count;
      send(8'hA5); send(8'h00); send(8'h01); send(8'h07);
      send_byte(8'h12);
      repeat (48) tick();
      checks++;
      if (tx_valid !== 1'b0) begin
         errors++;
         $display("FAIL timeout_early: tx_valid %b after 48 silent cycles, required 0", tx_valid);
      end
      tick();
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== 8'h15 || wr_count != wr_before) begin
         errors++;
         $display("FAIL timeout_nak: tx_valid %b tx_data %h writes %0d, required 1 15 0",
                  tx_valid, tx_data, wr_count - wr_before);
      end
      handshake();
      checks++;
      if (proc_reset !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL timeout_done: proc_reset %b busy %b, required 1 0", proc_reset, busy);
      end
      exp_q.push_back({10'd0, 2'd3, 16'hBEEF});
      send(8'hA5); send(8'h00); send(8'h01); send(8'h03); send(8'hBE); send(8'hEF);
      send_byte(8'h53);
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== 8'h06) begin
         errors++;
         $display("FAIL reload_ack: tx_valid %b tx_data %h, required 1 06", tx_valid, tx_data);
      end
      handshake();
      checks++;
      if (proc_reset !== 1'b0 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL reload_done: proc_reset %b pending %0d, required 0 0", proc_reset, exp_q.size());
      end
   endtask

   task automatic test_reset_mid_frame();
      exp_q.push_back({10'd0, 2'd1, 16'h2233});
      send(8'hA5); send(8'h00); send(8'h02);
      send(8'h01); send(8'h22); send(8'h33);
      send(8'h44); send(8'h55);
      rx_data  = 8'h66;
      rx_valid = 1'b1;
      reset    = 1'b1;
      tick();
      rx_valid = 1'b0;
      checks++;
      if ({tx_valid, tx_data, ram_we, ram_en, ram_addr, ram_di, ram_dip, proc_reset, busy} !== 39'd0) begin
         errors++;
         $display("FAIL reset_mid_frame: tx_valid %b tx_data %h we %b en %b addr %h di %h dip %h proc_reset %b busy %b, required all 0",
                  tx_valid, tx_data, ram_we, ram_en, ram_addr, ram_di, ram_dip, proc_reset, busy);
      end
      reset = 1'b0;
      tick();
      tick();
      checks++;
      if (exp_q.size() != 0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_after: pending %0d busy %b, required 0 0", exp_q.size(), busy);
      end
   endtask

   initial begin
      test_reset();
      test_two_word(8'h67, 8'h06, 1'b0, 1'b0);
      test_two_word(8'h00, 8'h15, 1'b1, 1'b1);
      test_oversize();
      test_full_frame();
      test_timeout();
      test_reset_mid_frame();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
